// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
package uart_pkg;

    localparam int   OVERSAMPLE_DEF = 16;
    localparam logic IDLE_LVL       = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divisor: one tick every baud_val+1 cycles while enabled.
module uart_baud_gen #(
    parameter int BITWIDTH = 8
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                enable,
    input  logic [BITWIDTH-1:0] baud_val,
    output logic                baud_tick
);

    logic [BITWIDTH-1:0] cnt;

    // >= so a divisor lowered below the running count ticks at once
    assign baud_tick = enable && (cnt >= baud_val);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (!enable || baud_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: holding register, frame FSM, shifter and parity.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BITWIDTH   = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [BITWIDTH-1:0] baud_val,
    input  logic [BITWIDTH-1:0] data_in,
    input  logic                tx_load,
    input  logic                parity_en,
    input  logic                odd_n_even,
    output logic                tx,
    output logic                tf_TXRDY,
    output logic                tx_busy
);

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(BITWIDTH);
    localparam logic [TW-1:0]  LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BIW-1:0] LAST_BIT  = BIW'(BITWIDTH - 1);

    tx_state_e           state;
    logic [BITWIDTH-1:0] hold_reg;
    logic                hold_full;
    logic [BITWIDTH-1:0] shifter;
    logic                par_en_q;
    logic                par_bit_q;
    logic [TW-1:0]       tick_cnt;
    logic [BIW-1:0]      bit_idx;
    logic                baud_en;
    logic                baud_tick;
    logic                bit_end;
    logic                xfer;
    logic                accept;

    assign baud_en  = (state != ST_IDLE);
    assign tx_busy  = baud_en;
    assign tf_TXRDY = ~hold_full;
    assign bit_end  = baud_tick && (tick_cnt == LAST_TICK);
    assign xfer     = hold_full &&
                      ((state == ST_IDLE) ||
                       ((state == ST_STOP) && bit_end));
    assign accept   = tx_load && !hold_full;

    uart_baud_gen #(
        .BITWIDTH (BITWIDTH)
    ) u_baud (
        .pclk      (pclk),
        .presetn   (presetn),
        .enable    (baud_en),
        .baud_val  (baud_val),
        .baud_tick (baud_tick)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (xfer) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= data_in;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            shifter   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= IDLE_LVL;
        end else if (xfer) begin
            // odd/even mode folds into the latched parity bit
            state     <= ST_START;
            shifter   <= hold_reg;
            par_en_q  <= parity_en;
            par_bit_q <= ^hold_reg ^ odd_n_even;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
        end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LAST_TICK) begin
                unique case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx    <= shifter[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == LAST_BIT) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                            tx    <= par_en_q ? par_bit_q : IDLE_LVL;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shifter <= shifter >> 1;
                            tx      <= shifter[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx    <= IDLE_LVL;
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= IDLE_LVL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: per-cycle line, busy and ready checks.
module tb_uart_tx_core;

    localparam int N = 1400;

    logic       pclk = 1'b0;
    logic       presetn;
    logic [7:0] baud_val;
    logic [7:0] data_in;
    logic       tx_load;
    logic       parity_en;
    logic       odd_n_even;
    logic       tx;
    logic       tf_TXRDY;
    logic       tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic       exp_tx   [N];
    logic       exp_busy [N];
    logic       exp_rdy  [N];
    int         load_idx [$];
    logic [7:0] load_val [$];
    int         baud_idx;
    logic [7:0] baud_new;
    int         nx;

    always #5 pclk = ~pclk;

    uart_tx_core dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .baud_val   (baud_val),
        .data_in    (data_in),
        .tx_load    (tx_load),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .tx         (tx),
        .tf_TXRDY   (tf_TXRDY),
        .tx_busy    (tx_busy)
    );

    task automatic check(input string tag, input logic got,
                         input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) begin
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
            exp_rdy[i]  = 1'b1;
        end
        load_idx.delete();
        load_val.delete();
        baud_idx = -1;
        baud_new = '0;
    endtask

    task automatic put(input int s, input int len, input logic v);
        for (int i = s; i < s + len; i++) begin
            exp_tx[i]   = v;
            exp_busy[i] = 1'b1;
        end
    endtask

    task automatic rdy_low(input int a, input int b);
        for (int i = a; i <= b; i++) exp_rdy[i] = 1'b0;
    endtask

    task automatic sched(input int idx, input logic [7:0] v);
        load_idx.push_back(idx);
        load_val.push_back(v);
    endtask

    task automatic frame(input int s, input logic [7:0] b,
                         input logic pen, input logic odd,
                         input int bl, input int sl,
                         output int nxt);
        int p;
        p = s;
        put(p, sl, 1'b0);
        p += sl;
        for (int k = 0; k < 8; k++) begin
            put(p, bl, b[k]);
            p += bl;
        end
        if (pen) begin
            put(p, bl, ^b ^ odd);
            p += bl;
        end
        put(p, bl, 1'b1);
        nxt = p + bl;
    endtask

    // sample i is taken 1ns after edge i; a load scheduled at i
    // is driven right after that sample
    task automatic play(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            check($sformatf("%s tx@%0d", name, i), tx, exp_tx[i]);
            check($sformatf("%s busy@%0d", name, i), tx_busy,
                  exp_busy[i]);
            check($sformatf("%s rdy@%0d", name, i), tf_TXRDY,
                  exp_rdy[i]);
            tx_load = 1'b0;
            for (int j = 0; j < load_idx.size(); j++) begin
                if (load_idx[j] == i) begin
                    tx_load = 1'b1;
                    data_in = load_val[j];
                end
            end
            if (i == baud_idx) baud_val = baud_new;
        end
        tx_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn    = 1'b1;
        tx_load    = 1'b0;
        data_in    = '0;
        baud_val   = '0;
        parity_en  = 1'b0;
        odd_n_even = 1'b0;
        #2 presetn = 1'b0;
        #1;
        check("rst tx", tx, 1'b1);
        check("rst rdy", tf_TXRDY, 1'b1);
        check("rst busy", tx_busy, 1'b0);
        repeat (3) @(posedge pclk);
        #3 presetn = 1'b1;

        clear_exp();
        sched(0, 8'h55);
        rdy_low(1, 1);
        frame(2, 8'h55, 1'b0, 1'b0, 16, 16, nx);
        play("single", 180);

        clear_exp();
        sched(0, 8'hA5);
        sched(2, 8'h3C);
        rdy_low(1, 1);
        rdy_low(3, 161);
        frame(2, 8'hA5, 1'b0, 1'b0, 16, 16, nx);
        frame(nx, 8'h3C, 1'b0, 1'b0, 16, 16, nx);
        play("b2b", 340);

        clear_exp();
        sched(0, 8'h11);
        sched(2, 8'h22);
        sched(10, 8'h33);
        sched(161, 8'h44);
        rdy_low(1, 1);
        rdy_low(3, 161);
        frame(2, 8'h11, 1'b0, 1'b0, 16, 16, nx);
        frame(nx, 8'h22, 1'b0, 1'b0, 16, 16, nx);
        play("overrun", 340);

        parity_en = 1'b1;
        clear_exp();
        sched(0, 8'h07);
        rdy_low(1, 1);
        frame(2, 8'h07, 1'b1, 1'b0, 16, 16, nx);
        play("par_even", 190);

        odd_n_even = 1'b1;
        clear_exp();
        sched(0, 8'h07);
        rdy_low(1, 1);
        frame(2, 8'h07, 1'b1, 1'b1, 16, 16, nx);
        play("par_odd", 190);
        parity_en  = 1'b0;
        odd_n_even = 1'b0;

        baud_val = 8'd3;
        clear_exp();
        sched(0, 8'h55);
        rdy_low(1, 1);
        frame(2, 8'h55, 1'b0, 1'b0, 64, 64, nx);
        play("baud3", 660);

        // count is 100 at sample 102; the shrink ticks at edge 103
        baud_val = 8'd200;
        clear_exp();
        sched(0, 8'hFF);
        rdy_low(1, 1);
        baud_idx = 102;
        baud_new = 8'd5;
        frame(2, 8'hFF, 1'b0, 1'b0, 96, 191, nx);
        play("baud_chg", 1070);
        baud_val = 8'd0;

        clear_exp();
        sched(0, 8'h55);
        rdy_low(1, 1);
        frame(2, 8'h55, 1'b0, 1'b0, 16, 16, nx);
        play("pre_rst", 70);
        #3 presetn = 1'b0;
        #1;
        check("midrst tx", tx, 1'b1);
        check("midrst rdy", tf_TXRDY, 1'b1);
        check("midrst busy", tx_busy, 1'b0);
        #1 presetn = 1'b1;

        clear_exp();
        play("post_rst", 200);

        clear_exp();
        sched(0, 8'h81);
        rdy_low(1, 1);
        frame(2, 8'h81, 1'b0, 1'b0, 16, 16, nx);
        play("reload", 180);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
